mips_cache_controller: RTL and testbench
========================================

MIPS_CACHE_CONTROLLER -- requirements
Module: mips_cache_controller

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255: maximum consecutive mem_waitrequest cycles before a timeout abort.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port addr, input, 32: CPU byte address, shared with the data cache.
REQ-005 SHALL have ports read_en and write_en, input, 1 each: CPU access strobes.
REQ-006 SHALL have port writedata, input, 32: CPU store data.
REQ-007 SHALL have port byte_en, input, 4: CPU store lane enables.
REQ-008 SHALL have port stall, input, 1: miss indication from the data cache.
REQ-009 SHALL have port data_in, output, 32: fill word to the data cache.
REQ-010 SHALL have port data_valid, output, 1: fill strobe to the data cache.
REQ-011 SHALL have port busy, output, 1: controller occupied; the CPU ORs it into its stall.
REQ-012 SHALL have ports mem_address (output, 32), mem_read (output, 1), mem_write (output, 1), mem_writedata (output, 32) and mem_byteenable (output, 4): memory request bus.
REQ-013 SHALL have ports mem_waitrequest (input, 1) and mem_readdata (input, 32): memory response; a transfer completes on a cycle with a request asserted and mem_waitrequest=0.
REQ-014 SHALL have port error, output, 1: sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, FILL and WRITE.
REQ-016 SHALL move IDLE->FETCH when stall=1 and (read_en|write_en)=1, latching mem_address={addr[31:2],2'b00}; this has priority over a write-through.
REQ-017 SHALL, in IDLE with write_en=1 and stall=0 (write hit), latch {addr[31:2],2'b00}, writedata and byte_en, then move to WRITE.
REQ-018 SHALL, in FETCH, hold mem_read=1 and mem_byteenable=4'b1111; on mem_waitrequest=0 it captures mem_readdata into data_in and moves to FILL.
REQ-019 SHALL, in FILL, drive data_valid=1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL hold data_in stable from capture until the next fetch completes.
REQ-021 SHALL, in WRITE, hold mem_write=1 with the latched address, data and byte enables; on mem_waitrequest=0 it returns to IDLE.
REQ-022 SHALL keep every mem_* request output stable while mem_waitrequest=1.
REQ-023 SHALL never assert mem_read and mem_write in the same cycle.
REQ-024 SHALL drive busy=1 in FETCH, FILL and WRITE, and busy=0 in IDLE.
REQ-025 SHALL drive mem_read=0 and mem_write=0 in IDLE.
REQ-026 SHALL ignore new CPU requests outside IDLE; a miss that is still pending (stall still high) is taken on return to IDLE, giving a WRITE->IDLE->FETCH sequence.
REQ-027 SHALL make an IDLE->FETCH transition one cycle after stall rises, and data_valid rise on the cycle after the memory accept.

Reset
REQ-028 SHALL, on rst=1 (asynchronously, including mid-transfer), force state=IDLE; data_in=0; data_valid, busy, mem_read, mem_write and error=0; mem_address, mem_writedata and mem_byteenable=0.
REQ-029 SHALL, after reset release, take its first action no earlier than the first posedge clk.

Configuration
REQ-030 SHALL gate a timeout feature with macro MIPS_CACHE_CTRL_TIMEOUT_EN.
REQ-031 SHALL, when MIPS_CACHE_CTRL_TIMEOUT_EN is defined, count consecutive waitrequest cycles in FETCH or WRITE; on reaching WAIT_LIMIT it drops the request, sets error=1 (sticky until rst) and returns to IDLE without pulsing data_valid.
REQ-032 SHALL, when MIPS_CACHE_CTRL_TIMEOUT_EN is undefined, have no counter, tie error to 0 and wait indefinitely.

Verification
REQ-033 SHALL cover a read miss: addr=0x00000104, read_en=1, stall=1, waitrequest=0 -> mem_read=1 at 0x00000104; next cycle data_valid=1 with data_in=mem_readdata=0xDEADBEEF; busy=0 after.
REQ-034 SHALL cover a miss under wait: 3 cycles of mem_waitrequest=1 -> mem_read and mem_address stable for 4 cycles, then a single data_valid pulse.
REQ-035 SHALL cover a write hit: write_en=1, stall=0, addr=0x00000203, writedata=0x11223344, byte_en=4'b0011 -> mem_write=1, mem_address=0x00000200, mem_byteenable=4'b0011, 1 cycle.
REQ-036 SHALL cover a write miss: write_en=1, stall=1 -> FETCH+FILL first; after stall drops, a write-through follows.
REQ-037 SHALL cover asynchronous reset mid-FETCH: rst=1 between clock edges -> mem_read=0 and busy=0 immediately; no data_valid follows.
REQ-038 SHALL cover timeout (macro defined, WAIT_LIMIT=4): waitrequest held 1 -> mem_read drops after 4 cycles, error=1 and stays 1 until rst.

Source files
------------

// File: rtl/mips_cache_controller.sv
// mips_cache_controller: sequences data-cache miss fills and write-through stores onto a waitrequest memory bus.
// Optional waitrequest timeout with sticky error is compiled in by defining MIPS_CACHE_CTRL_TIMEOUT_EN.
module mips_cache_controller #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] writedata,
  input  logic [3:0]  byte_en,
  input  logic        stall,
  output logic [31:0] data_in,
  output logic        data_valid,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        error
);
  typedef enum logic [1:0] {IDLE, FETCH, FILL, WRITE} state_t;
  state_t state, state_n;
  logic req, accept, timeout;
  assign req        = (state == FETCH) || (state == WRITE);
  assign accept     = req && !mem_waitrequest;
  assign mem_read   = state == FETCH;
  assign mem_write  = state == WRITE;
  assign data_valid = state == FILL;
  assign busy       = state != IDLE;
`ifdef MIPS_CACHE_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  logic [CW-1:0] wait_cnt;
  assign timeout = req && mem_waitrequest && (wait_cnt == CW'(WAIT_LIMIT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      wait_cnt <= (req && mem_waitrequest && !timeout) ? wait_cnt + 1'b1 : '0;
      if (timeout) error <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif
  // A miss outranks a write-through so the line is resident before the store is forwarded.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (stall && (read_en || write_en)) ? FETCH : write_en ? WRITE : IDLE;
      FETCH:   state_n = accept ? FILL : timeout ? IDLE : FETCH;
      FILL:    state_n = IDLE;
      WRITE:   state_n = (accept || timeout) ? IDLE : WRITE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      data_in        <= '0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) mem_address <= {addr[31:2], 2'b00};
      if (state == IDLE && state_n == FETCH) mem_byteenable <= 4'b1111;
      if (state == IDLE && state_n == WRITE) begin
        mem_writedata  <= writedata;
        mem_byteenable <= byte_en;
      end
      if (state == FETCH && accept) data_in <= mem_readdata;
    end
endmodule

// File: tb/tb_mips_cache_controller.sv
// tb_mips_cache_controller: scoreboard bench; bus transfers and fills are popped from an expectation queue as they occur.
module tb_mips_cache_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] addr = '0, writedata = '0, mem_readdata = '0;
  logic read_en = 1'b0, write_en = 1'b0, stall = 1'b0, mem_waitrequest = 1'b0;
  logic [3:0] byte_en = '0;
  logic [31:0] data_in, mem_address, mem_writedata;
  logic data_valid, busy, mem_read, mem_write, error;
  logic [3:0] mem_byteenable;
  int total = 0, bad = 0;
  typedef struct {int kind; logic [31:0] a; logic [31:0] d; logic [3:0] be;} exp_t;
  exp_t sb[$];
  logic prev_hold = 1'b0;
  logic [31:0] prev_a, prev_d;
  logic [3:0] prev_be;

  mips_cache_controller #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
    .writedata(writedata), .byte_en(byte_en), .stall(stall), .data_in(data_in),
    .data_valid(data_valid), .busy(busy), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sb.push_back('{k, a, d, be});
  endtask

  task automatic pop(input int k, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_kind"}, k, e.kind);
    if (k == 1) check({tag, "_data"}, data_in, e.d);
    else begin
      check({tag, "_addr"}, mem_address, e.a);
      check({tag, "_be"}, mem_byteenable, e.be);
      if (k == 2) check({tag, "_wdata"}, mem_writedata, e.d);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic r, input logic w, input logic s, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    read_en = r; write_en = w; stall = s; addr = a; writedata = wd; byte_en = be;
  endtask

  // Bus monitor: transfers, fills, mutual exclusion and request stability under waitrequest.
  always @(negedge clk) begin
    if (rst) prev_hold = 1'b0;
    else begin
      check("rw_excl", {31'd0, mem_read & mem_write}, 32'd0);
      if (prev_hold) begin
        check("hold_addr", mem_address, prev_a);
        check("hold_wdata", mem_writedata, prev_d);
        check("hold_be", mem_byteenable, prev_be);
      end
      if (mem_read && !mem_waitrequest) pop(0, "rd");
      if (mem_write && !mem_waitrequest) pop(2, "wr");
      if (data_valid) pop(1, "fill");
      prev_hold = (mem_read | mem_write) & mem_waitrequest;
      prev_a = mem_address; prev_d = mem_writedata; prev_be = mem_byteenable;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_rdwr", {mem_read, mem_write, data_valid, error}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", data_in, 0);
    @(posedge clk); #3 rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    // read miss, no wait
    mem_readdata = 32'hDEADBEEF;
    cpu(1, 0, 1, 32'h104, 0, 0);
    push(0, 32'h104, 0, 4'hf); push(1, 0, 32'hDEADBEEF, 0);
    tick();
    cpu(0, 0, 0, 0, 0, 0);
    check("rm_read", mem_read, 1);
    check("rm_busy", busy, 1);
    check("rm_addr", mem_address, 32'h104);
    tick();
    check("rm_valid", data_valid, 1);
    check("rm_din", data_in, 32'hDEADBEEF);
    mem_readdata = 32'h0;
    tick();
    check("rm_done", {busy, data_valid}, 0);
    tick();
    check("rm_din_hold", data_in, 32'hDEADBEEF);
    // read miss with three wait cycles
    mem_waitrequest = 1'b1; mem_readdata = 32'hA5A50001;
    cpu(1, 0, 1, 32'h2009, 0, 0);
    push(0, 32'h2008, 0, 4'hf); push(1, 0, 32'hA5A50001, 0);
    tick();
    cpu(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("mw_read", mem_read, 1);
      check("mw_addr", mem_address, 32'h2008);
      check("mw_novalid", data_valid, 0);
      tick();
      if (i == 2) mem_waitrequest = 1'b0;
    end
    check("mw_valid", data_valid, 1);
    tick();
    check("mw_single", data_valid, 0);
    // write hit
    cpu(0, 1, 0, 32'h203, 32'h11223344, 4'b0011);
    push(2, 32'h200, 32'h11223344, 4'b0011);
    tick();
    cpu(0, 0, 0, 0, 0, 0);
    check("wh_write", {mem_read, mem_write}, 1);
    check("wh_addr", mem_address, 32'h200);
    check("wh_be", mem_byteenable, 4'b0011);
    tick();
    check("wh_done", {busy, mem_write}, 0);
    // write miss: fetch+fill, then write-through
    mem_readdata = 32'h55AA55AA;
    cpu(0, 1, 1, 32'h30A, 32'hCAFEF00D, 4'b1111);
    push(0, 32'h308, 0, 4'hf); push(1, 0, 32'h55AA55AA, 0); push(2, 32'h308, 32'hCAFEF00D, 4'hf);
    tick();
    check("wm_fetch", {mem_read, mem_write}, 2);
    stall = 1'b0;
    tick();
    check("wm_fill", data_valid, 1);
    tick();
    check("wm_idle", busy, 0);
    tick();
    cpu(0, 0, 0, 0, 0, 0);
    check("wm_write", mem_write, 1);
    check("wm_addr", mem_address, 32'h308);
    tick();
    // miss raised during a write is taken after it
    mem_waitrequest = 1'b1;
    cpu(0, 1, 0, 32'h400, 32'h0BADC0DE, 4'b1100);
    push(2, 32'h400, 32'h0BADC0DE, 4'b1100);
    tick();
    cpu(1, 0, 1, 32'h500, 0, 0);
    tick();
    check("pm_ignore", mem_address, 32'h400);
    check("pm_noread", mem_read, 0);
    mem_waitrequest = 1'b0;
    mem_readdata = 32'h13572468;
    push(0, 32'h500, 0, 4'hf); push(1, 0, 32'h13572468, 0);
    tick();
    check("pm_idle", busy, 0);
    tick();
    cpu(0, 0, 0, 0, 0, 0);
    check("pm_fetch", mem_read, 1);
    check("pm_addr", mem_address, 32'h500);
    tick(2);
    // asynchronous reset in the middle of a fetch
    mem_waitrequest = 1'b1;
    cpu(1, 0, 1, 32'h600, 0, 0);
    tick();
    cpu(0, 0, 0, 0, 0, 0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("ar_read", mem_read, 0);
    check("ar_busy", busy, 0);
    check("ar_addr", mem_address, 0);
    check("ar_din", data_in, 0);
    @(posedge clk); #3 rst = 1'b0; mem_waitrequest = 1'b0;
    tick(3);
    check("ar_quiet", {busy, data_valid, mem_read}, 0);
    // waitrequest held high
    mem_waitrequest = 1'b1;
    cpu(1, 0, 1, 32'h700, 0, 0);
`ifdef MIPS_CACHE_CTRL_TIMEOUT_EN
    tick();
    cpu(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("to_read", mem_read, 1);
      check("to_err0", error, 0);
      tick();
    end
    check("to_drop", {mem_read, busy}, 0);
    check("to_err", error, 1);
    mem_waitrequest = 1'b0;
    tick(3);
    check("to_sticky", error, 1);
    check("to_novalid", data_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("to_clear", error, 0);
`else
    mem_readdata = 32'h77777777;
    push(0, 32'h700, 0, 4'hf); push(1, 0, 32'h77777777, 0);
    tick();
    cpu(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("nt_read", mem_read, 1);
      check("nt_err", error, 0);
      tick();
    end
    mem_waitrequest = 1'b0;
    tick();
    check("nt_fill", data_valid, 1);
    tick();
    check("nt_err_end", error, 0);
`endif
    tick(2);
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
